// File: rtl/lvt_bram_wr_arbiter.sv
// Front-end for lvt_bram. After reset it sweeps the memory to zero, then maps up to two write
// requesters per cycle onto wr0/wr1 in round-robin order and sequences one read client via rd0.
module lvt_bram_wr_arbiter #(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DATA_W = 5,
   parameter int unsigned NREQ   = 4,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     rd_valid,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic                     rd_ready,
   output logic                     rsp_valid,
   output logic [DATA_W-1:0]        rsp_data,
   output logic                     init_done,
   output logic                     wr0_en,
   output logic [ADDR_W-1:0]        wr0_addr,
   output logic [DATA_W-1:0]        wr0_data,
   output logic                     wr1_en,
   output logic [ADDR_W-1:0]        wr1_addr,
   output logic [DATA_W-1:0]        wr1_data,
   output logic                     rd0_en,
   output logic [ADDR_W-1:0]        rd0_addr,
   input  logic [DATA_W-1:0]        rd0_data
);

   localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [ADDR_W-1:0] LAST_PAIR = {{(ADDR_W-1){1'b1}}, 1'b0};

   typedef enum logic {StInit, StRun} state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   sweep_q;
   logic [IDX_W-1:0]    rr_q;
   logic [RD_LAT-1:0]   rd_pipe_q;

   logic                g0_vld, g1_vld;
   logic [IDX_W-1:0]    g0_idx, g1_idx, cur_idx, rr_d;
   logic [IDX_W:0]      scan, rr_inc;
   logic [ADDR_W-1:0]   g0_addr, g1_addr, cur_addr;
   logic [DATA_W-1:0]   g0_data, g1_data;
   logic                rd_accept;

   // Rotating scan from rr_q: first valid takes port 0, next valid at a different address port 1.
   always_comb begin
      g0_vld    = 1'b0;
      g1_vld    = 1'b0;
      g0_idx    = '0;
      g1_idx    = '0;
      g0_addr   = '0;
      g1_addr   = '0;
      g0_data   = '0;
      g1_data   = '0;
      scan      = '0;
      cur_idx   = '0;
      cur_addr  = '0;
      req_ready = '0;
      if (state_q == StRun) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            scan = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (scan >= (IDX_W+1)'(NREQ)) scan = scan - (IDX_W+1)'(NREQ);
            cur_idx  = scan[IDX_W-1:0];
            cur_addr = req_addr[cur_idx*ADDR_W +: ADDR_W];
            if (req_valid[cur_idx]) begin
               if (!g0_vld) begin
                  g0_vld  = 1'b1;
                  g0_idx  = cur_idx;
                  g0_addr = cur_addr;
                  g0_data = req_data[cur_idx*DATA_W +: DATA_W];
               end else if (!g1_vld && cur_addr != g0_addr) begin
                  g1_vld  = 1'b1;
                  g1_idx  = cur_idx;
                  g1_addr = cur_addr;
                  g1_data = req_data[cur_idx*DATA_W +: DATA_W];
               end
            end
         end
      end
      if (g0_vld) req_ready[g0_idx] = 1'b1;
      if (g1_vld) req_ready[g1_idx] = 1'b1;
      rr_inc = {1'b0, (g1_vld ? g1_idx : g0_idx)} + (IDX_W+1)'(1);
      rr_d   = (rr_inc == (IDX_W+1)'(NREQ)) ? '0 : rr_inc[IDX_W-1:0];
      // Stall a read that targets an address being granted, so it cannot race the write.
      rd_ready = (state_q == StRun) &&
                 !(g0_vld && rd_addr == g0_addr) &&
                 !(g1_vld && rd_addr == g1_addr);
   end

   assign rd_accept = rd_valid & rd_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StInit;
         sweep_q   <= '0;
         rr_q      <= '0;
         rd_pipe_q <= '0;
         init_done <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         wr0_en    <= 1'b0;
         wr0_addr  <= '0;
         wr0_data  <= '0;
         wr1_en    <= 1'b0;
         wr1_addr  <= '0;
         wr1_data  <= '0;
         rd0_en    <= 1'b0;
         rd0_addr  <= '0;
      end else begin
         rd_pipe_q[0] <= rd0_en;
         for (int k = 1; k < int'(RD_LAT); k++) rd_pipe_q[k] <= rd_pipe_q[k-1];
         rsp_valid <= rd_pipe_q[RD_LAT-1];
         if (rd_pipe_q[RD_LAT-1]) rsp_data <= rd0_data;
         case (state_q)
            StInit: begin
               wr0_en   <= 1'b1;
               wr0_addr <= sweep_q;
               wr0_data <= '0;
               wr1_en   <= 1'b1;
               wr1_addr <= sweep_q | ADDR_W'(1);
               wr1_data <= '0;
               sweep_q  <= sweep_q + ADDR_W'(2);
               if (sweep_q == LAST_PAIR) begin
                  state_q   <= StRun;
                  init_done <= 1'b1;
               end
            end
            StRun: begin
               wr0_en   <= g0_vld;
               wr0_addr <= g0_addr;
               wr0_data <= g0_data;
               wr1_en   <= g1_vld;
               wr1_addr <= g1_addr;
               wr1_data <= g1_data;
               rd0_en   <= rd_accept;
               if (rd_accept) rd0_addr <= rd_addr;
               if (g0_vld) rr_q <= rr_d;
            end
            default: state_q <= StInit;
         endcase
      end
   end

endmodule
